// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Smallest r such that 2**r >= n; a depth of 8 gives a 3-bit pointer.
    function automatic int clog2w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int af_thresh, input int ae_thresh);
        bit ok;
        ok = 1'b1;
        if (width < 1) ok = 1'b0;
        if (depth < 2) ok = 1'b0;
        if ((depth & (depth - 1)) != 0) ok = 1'b0;
        if (af_thresh < 0 || af_thresh > depth) ok = 1'b0;
        if (ae_thresh < 0 || ae_thresh >= depth) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle of the synchronous FIFO; the FIFO itself takes the slave view.
interface fifo_sync_param_if #(
    parameter int WIDTH = fifo_pkg::DEF_WIDTH,
    parameter int DEPTH = fifo_pkg::DEF_DEPTH
);
    localparam int AW = fifo_pkg::clog2w(DEPTH);

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and an optional first-word-fall-through read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_param_if.slave bus
);

    localparam int AW = clog2w(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    generate
        if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
            $fatal(1, "fifo_sync_param: illegal WIDTH/DEPTH/threshold combination");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             full, empty;
    logic             wr_acc, rd_acc;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    // A pop frees a slot in the same edge, so a write into a full FIFO is accepted alongside it.
    assign rd_acc = bus.rd_en & ~empty;
    assign wr_acc = bus.wr_en & (~full | rd_acc);
    assign mem_we = wr_acc & ~bus.clr;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dout_d      = dout_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.wr_en & ~wr_acc);
            underflow_d = underflow_q | (bus.rd_en & ~rd_acc);
            if ((FWFT == 0) && rd_acc) dout_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
        end
    end

    // In FWFT mode the head word is shown straight from the array; forced to 0 while empty.
    assign bus.data_out     = (FWFT != 0) ? (empty ? '0 : mem_rdata) : dout_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a vector table on a registered-read instance,
// plus hand sequences for FWFT mode and asynchronous reset.
module tb_fifo_sync_param;

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       uf;
        logic [7:0] dout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(8)) b0 ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(8)) b1 ();

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are derived from the expected count with the bench's thresholds (AF=6, AE=2, DEPTH=8).
    task automatic addVec(input logic clr, input logic wr, input logic rd, input logic [7:0] din,
                          input int cnt, input logic ov, input logic uf, input logic [7:0] dout);
        vec_t v;
        v.clr   = clr;
        v.wr    = wr;
        v.rd    = rd;
        v.din   = din;
        v.count = 4'(cnt);
        v.full  = (cnt == 8);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 6);
        v.ae    = (cnt <= 2);
        v.ov    = ov;
        v.uf    = uf;
        v.dout  = dout;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic clr, input logic wr, input logic rd, input logic [7:0] din);
        b0.clr     = clr;
        b0.wr_en   = wr;
        b0.rd_en   = rd;
        b0.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVec(input string tag, input vec_t v);
        checkOutput({tag, " count"}, int'(b0.count), int'(v.count));
        checkOutput({tag, " full"}, int'(b0.full), int'(v.full));
        checkOutput({tag, " empty"}, int'(b0.empty), int'(v.empty));
        checkOutput({tag, " almost_full"}, int'(b0.almost_full), int'(v.af));
        checkOutput({tag, " almost_empty"}, int'(b0.almost_empty), int'(v.ae));
        checkOutput({tag, " overflow"}, int'(b0.overflow), int'(v.ov));
        checkOutput({tag, " underflow"}, int'(b0.underflow), int'(v.uf));
        checkOutput({tag, " data_out"}, int'(b0.data_out), int'(v.dout));
    endtask

    initial begin
        vec_t rv;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        b0.clr = 1'b0; b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.data_in = 8'h00;
        b1.clr = 1'b0; b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.data_in = 8'h00;

        // Fill to full, overflow attempt, drain in order.
        for (int k = 1; k <= 8; k++) addVec(1'b0, 1'b1, 1'b0, 8'(17 * k), k, 1'b0, 1'b0, 8'h00);
        addVec(1'b0, 1'b1, 1'b0, 8'h99, 8, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 8; k++) addVec(1'b0, 1'b0, 1'b1, 8'h00, 8 - k, 1'b1, 1'b0, 8'(17 * k));
        // Underflow from empty, then flush clears the sticky flags.
        addVec(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h88);
        addVec(1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 8'h88);
        // Refill, simultaneous push/pop while full, then drain the wrapped 0xAA words.
        for (int k = 1; k <= 8; k++) addVec(1'b0, 1'b1, 1'b0, 8'(17 * k), k, 1'b0, 1'b0, 8'h88);
        for (int k = 1; k <= 8; k++) addVec(1'b0, 1'b1, 1'b1, 8'hAA, 8, 1'b0, 1'b0, 8'(17 * k));
        for (int k = 1; k <= 8; k++) addVec(1'b0, 1'b0, 1'b1, 8'h00, 8 - k, 1'b0, 1'b0, 8'hAA);

        #12;
        rv.clr = 1'b0; rv.wr = 1'b0; rv.rd = 1'b0; rv.din = 8'h00;
        rv.count = 4'd0; rv.full = 1'b0; rv.empty = 1'b1; rv.af = 1'b0; rv.ae = 1'b1;
        rv.ov = 1'b0; rv.uf = 1'b0; rv.dout = 8'h00;
        checkVec("reset", rv);
        checkOutput("reset fwft empty", int'(b1.empty), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle discards entries and sticky flags before the next edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("pre-reset underflow", int'(b0.underflow), 1);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("pre-reset count", int'(b0.count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        rv.count = 4'd0; rv.full = 1'b0; rv.empty = 1'b1; rv.af = 1'b0; rv.ae = 1'b1;
        rv.ov = 1'b0; rv.uf = 1'b0; rv.dout = 8'h00;
        checkVec("async reset", rv);
        #3;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        b0.rd_en = 1'b0;
        rv.uf = 1'b1;
        checkVec("post-reset read", rv);

        // FWFT instance: head word visible without a read request.
        b1.wr_en = 1'b1; b1.data_in = 8'h5A;
        @(posedge clk); #1;
        b1.wr_en = 1'b0;
        checkOutput("fwft first word", int'(b1.data_out), 8'h5A);
        checkOutput("fwft count1", int'(b1.count), 1);
        checkOutput("fwft not empty", int'(b1.empty), 0);
        b1.wr_en = 1'b1; b1.data_in = 8'h5B;
        @(posedge clk); #1;
        b1.wr_en = 1'b0;
        checkOutput("fwft head held", int'(b1.data_out), 8'h5A);
        checkOutput("fwft count2", int'(b1.count), 2);
        b1.rd_en = 1'b1;
        @(posedge clk); #1;
        b1.rd_en = 1'b0;
        checkOutput("fwft second word", int'(b1.data_out), 8'h5B);
        checkOutput("fwft count after pop", int'(b1.count), 1);
        b1.rd_en = 1'b1;
        @(posedge clk); #1;
        b1.rd_en = 1'b0;
        checkOutput("fwft empty after pops", int'(b1.empty), 1);
        checkOutput("fwft count zero", int'(b1.count), 0);
        checkOutput("fwft no underflow", int'(b1.underflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO that succeeds the fixed 8-bit FIFO.
- Generalises data width and depth, and adds an occupancy count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in one clock domain, as the standard buffering element.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; must be a power of 2, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode.
- Derived (localparam): AW = log2(DEPTH); count is AW+1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers = 0, count = 0, data_out = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
- Acceptance is decided on the rising edge:
  - wr_acc = wr_en & (~full | rd_acc)
  - rd_acc = rd_en & ~empty
- Full and empty boundaries:
  - Full with simultaneous wr_en and rd_en: both are accepted, count is unchanged, and the oldest word is popped.
  - Empty with simultaneous wr_en and rd_en: only the write is accepted and underflow is set. No same-cycle bypass in either mode.
- Pointers: wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags:
  - full, empty, almost_* are combinational from the registered count.
  - They reflect the state after the edge that updated count, with no extra latency.
- Registered-read mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr]; the word is valid in the cycle after the rd_en edge.
  - data_out holds its value otherwise, including when a read is refused.
- FWFT mode (FWFT=1):
  - data_out continuously shows the head word whenever empty=0. The word is visible the cycle after the write that made the FIFO non-empty.
  - rd_acc advances to the next word, which is visible the following cycle.
  - data_out is don't-care while empty=1.
- Sticky error flags:
  - overflow <= 1 when wr_en & ~wr_acc; the word is dropped and the memory is unchanged.
  - underflow <= 1 when rd_en & ~rd_acc.
  - Both hold until clr or reset.
- clr=1 at an edge:
  - pointers and count go to 0; overflow and underflow clear.
  - wr_en and rd_en are ignored that cycle; clr has priority.
  - data_out: held in FWFT=0; don't-care in FWFT=1.
- Thresholds:
  - AF_THRESH <= DEPTH and AE_THRESH < DEPTH are checked at elaboration. A violation is a fatal error.

Decomposition:
- Package fifo_pkg holds:
  - the clog2-style width function;
  - default WIDTH/DEPTH constants;
  - parameter-check helper.
- One sub-module, fifo_mem_2p: a simple dual-port register array with synchronous write port and asynchronous read address port.
- The top level owns the pointers, count, flags and the data_out register.

Test Plan (WIDTH=8, DEPTH=8, AF=6, AE=2):
1. Reset, then write 0x11..0x88 over 8 cycles → count steps 1..8; almost_empty drops when count=3; almost_full rises at count=6; full=1 at 8; no overflow.
2. From full, write 0x99 with rd_en=0 → count stays 8, overflow=1 and stays high; subsequent reads return 0x11..0x88 in order (0x99 absent).
3. From empty, rd_en=1 → underflow=1, count=0, data_out unchanged. Then clr=1 for one cycle → underflow=0, overflow=0, count=0.
4. Full, then wr_en=rd_en=1 with 0xAA for 8 cycles → count stays 8, data_out sequence is 0x11..0x88, no overflow. Then 8 reads return 0xAA ×8, confirming wrap-around.
5. FWFT=1 instance: write 0x5A → data_out=0x5A the next cycle with no rd_en. Write 0x5B, then pop → data_out=0x5B next cycle; pop again → empty=1, count=0.
6. Write 3 words, assert rst_n=0 asynchronously mid-cycle → count=0, empty=1, flags cleared before the next clk edge. After release, a read gives underflow and no stale data is counted.
